var_delay_line: RTL and testbench



---
 rtl/var_delay_line.sv | 64 ++++++
 tb/tb_var_delay_line.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/var_delay_line.sv
// Runtime-programmable delay line: circular buffer with a combinational variable tap
// and fill tracking so that only genuinely written samples reach the output.
module var_delay_line #(
  parameter int N  = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          clr,
  input  logic [AW-1:0] delay,
  input  logic [N-1:0]  idata,
  output logic [N-1:0]  odata,
  output logic          ovalid
);

  localparam int D = 1 << AW;
  localparam logic [AW-1:0] FILL_MAX = AW'(D - 1);

  logic [N-1:0]  mem [D];
  logic [AW-1:0] wptr;
  logic [AW-1:0] fill;
  logic [AW-1:0] rptr;
  logic          write_en;

  // clr outranks ce, and nothing is written while reset is held
  assign write_en = ce && !clr && !rst;

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wptr] <= idata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      fill <= '0;
    end else if (clr) begin
      fill <= '0;
    end else if (ce) begin
      wptr <= wptr + 1'b1;
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  assign rptr = wptr - delay;

  // Stale buffer contents are masked to zero until fill covers the selected tap
  always_comb begin
    odata  = '0;
    ovalid = 1'b0;
    if (delay == '0) begin
      odata  = idata;
      ovalid = !rst;
    end else if (!rst && (fill >= delay)) begin
      odata  = mem[rptr];
      ovalid = 1'b1;
    end
  end

endmodule

// File: tb/tb_var_delay_line.sv
// Self-checking bench for var_delay_line: vector table, directed corner sequences
// and randomized traffic against a history-queue reference model.
module tb_var_delay_line;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          clr;
  logic [AW-1:0] delay;
  logic [N-1:0]  idata;
  logic [N-1:0]  odata;
  logic          ovalid;

  var_delay_line #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .clr(clr),
    .delay(delay), .idata(idata), .odata(odata), .ovalid(ovalid)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference: samples written since reset (newest at the back) and writes since last flush
  logic [N-1:0] hist [$];
  int           mfill;

  typedef struct {
    logic          ce;
    logic          clr;
    logic [AW-1:0] delay;
    logic [N-1:0]  idata;
    logic          ev;
    logic [N-1:0]  ed;
  } vec_t;

  vec_t tbl [$];

  task automatic cmp(input string name, input int got, input int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_expect(output logic ev, output logic [N-1:0] ed);
    int d;
    d = int'(delay);
    if (rst) begin
      ev = 1'b0;
      ed = (d == 0) ? idata : '0;
    end else if (d == 0) begin
      ev = 1'b1;
      ed = idata;
    end else if (mfill >= d) begin
      ev = 1'b1;
      ed = hist[hist.size() - d];
    end else begin
      ev = 1'b0;
      ed = '0;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      hist.delete();
      mfill = 0;
    end else if (clr) begin
      mfill = 0;
    end else if (ce) begin
      hist.push_back(idata);
      if (hist.size() > D) void'(hist.pop_front());
      if (mfill < D - 1) mfill++;
    end
  endtask

  task automatic check_model(input string name);
    logic         ev;
    logic [N-1:0] ed;
    model_expect(ev, ed);
    cmp({name, " ovalid"}, int'(ovalid), int'(ev));
    cmp({name, " odata"}, int'(odata), int'(ed));
  endtask

  // Apply inputs, check pre-edge outputs at the falling edge, then clock the model
  task automatic cycle(input logic c, input logic cl, input logic [AW-1:0] dl,
                       input logic [N-1:0] din, input string name);
    ce = c; clr = cl; delay = dl; idata = din;
    @(negedge clk);
    check_model(name);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce = 1'b0; clr = 1'b0; delay = '0; idata = '0;
    hist.delete();
    mfill = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; clr = 1'b0; delay = 4'd3; idata = '0;
    #2;
    cmp("reset ovalid", int'(ovalid), 0);
    cmp("reset odata", int'(odata), 0);
    do_reset();

    // delay=0 passthrough right after reset
    ce = 1'b0; delay = '0; idata = 4'hA;
    #1;
    cmp("d0 ovalid", int'(ovalid), 1);
    cmp("d0 odata", int'(odata), 'hA);

    // Vector table: delay=3 fill-up, delay=0 passthrough, clr with ce at delay=1
    tbl.push_back('{1'b1, 1'b0, 4'd3, 4'd1, 1'b0, 4'd0});
    tbl.push_back('{1'b1, 1'b0, 4'd3, 4'd2, 1'b0, 4'd0});
    tbl.push_back('{1'b1, 1'b0, 4'd3, 4'd3, 1'b0, 4'd0});
    tbl.push_back('{1'b1, 1'b0, 4'd3, 4'd4, 1'b1, 4'd1});
    tbl.push_back('{1'b1, 1'b0, 4'd3, 4'd5, 1'b1, 4'd2});
    tbl.push_back('{1'b1, 1'b0, 4'd3, 4'd6, 1'b1, 4'd3});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 4'hA, 1'b1, 4'hA});
    tbl.push_back('{1'b1, 1'b1, 4'd1, 4'd7, 1'b1, 4'd6});
    tbl.push_back('{1'b0, 1'b0, 4'd1, 4'd8, 1'b0, 4'd0});
    tbl.push_back('{1'b1, 1'b0, 4'd1, 4'd9, 1'b0, 4'd0});
    tbl.push_back('{1'b0, 1'b0, 4'd1, 4'd2, 1'b1, 4'd9});
    for (int i = 0; i < tbl.size(); i++) begin
      ce = tbl[i].ce; clr = tbl[i].clr; delay = tbl[i].delay; idata = tbl[i].idata;
      @(negedge clk);
      cmp($sformatf("vec%0d ovalid", i), int'(ovalid), int'(tbl[i].ev));
      cmp($sformatf("vec%0d odata", i), int'(odata), int'(tbl[i].ed));
      @(posedge clk);
      model_edge();
      #1;
    end

    // ce freeze at delay=2: outputs hold, stream resumes without skips
    do_reset();
    for (int k = 1; k <= 4; k++) cycle(1'b1, 1'b0, 4'd2, 4'(k), "run2");
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 4'd2, 4'(k + 9), "freeze");
      cmp("freeze odata held", int'(odata), 3);
    end
    for (int k = 5; k <= 8; k++) cycle(1'b1, 1'b0, 4'd2, 4'(k), "resume");

    // delay=15 over 40 writes: saturation and two pointer wraps
    do_reset();
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, 1'b0, 4'd15, 4'(k), "d15");
      if (k == 14) cmp("d15 rise", int'(ovalid), 1);
    end
    ce = 1'b0;
    #1;
    check_model("d15 final");

    // delay increase beyond fill drops ovalid until refilled
    do_reset();
    for (int k = 1; k <= 5; k++) cycle(1'b1, 1'b0, 4'd2, 4'(k), "pre7");
    cycle(1'b0, 1'b0, 4'd7, 4'd0, "switch7");
    cmp("switch7 low", int'(ovalid), 0);
    for (int k = 6; k <= 8; k++) cycle(1'b1, 1'b0, 4'd7, 4'(k), "post7");
    cmp("post7 high", int'(ovalid), 1);

    // asynchronous reset mid-stream
    delay = 4'd2;
    #1;
    cmp("pre-rst ovalid", int'(ovalid), 1);
    #1;
    rst = 1'b1;
    #1;
    cmp("async rst ovalid", int'(ovalid), 0);
    cmp("async rst odata", int'(odata), 0);
    hist.delete();
    mfill = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic          c, cl;
      logic [AW-1:0] dl;
      c  = ($urandom_range(0, 9) < 7);
      cl = ($urandom_range(0, 39) == 0);
      dl = (i % 50 < 25) ? AW'($urandom_range(0, 4)) : AW'($urandom_range(0, D - 1));
      cycle(c, cl, dl, N'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
